// File: rtl/slot_alloc_pkg.sv
// Shared helpers for the slot allocator: index-width derivation used by the
// allocator, its interface and the find-first-set encoder.
package slot_alloc_pkg;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/slot_alloc_if.sv
// Allocation / release / status bundle between a slot allocator and its client.
interface slot_alloc_if
    import slot_alloc_pkg::*;
#(
    parameter int N = 32
);
    localparam int IDXW = idx_w(N);

    logic            alloc_req;
    logic            alloc_gnt;
    logic [IDXW-1:0] alloc_idx;
    logic [N-1:0]    alloc_onehot;
    logic            free_vld;
    logic [IDXW-1:0] free_idx;
    logic            flush;
    logic [N-1:0]    busy_vec;
    logic [IDXW:0]   free_cnt;
    logic            full;
    logic            empty;
    logic            err_dbl_free;

    modport master (
        output alloc_req, free_vld, free_idx, flush,
        input  alloc_gnt, alloc_idx, alloc_onehot, busy_vec, free_cnt, full, empty, err_dbl_free
    );

    modport slave (
        input  alloc_req, free_vld, free_idx, flush,
        output alloc_gnt, alloc_idx, alloc_onehot, busy_vec, free_cnt, full, empty, err_dbl_free
    );
endinterface

// File: rtl/slot_alloc_ffs_n.sv
// Generic find-first-set: flags, isolates (one-hot) and encodes the lowest set
// bit of a W-bit vector.
module ffs_n
    import slot_alloc_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [W-1:0]          vec_i,
    output logic                  found_o,
    output logic [W-1:0]          onehot_o,
    output logic [idx_w(W)-1:0]   idx_o
);
    localparam int IW = idx_w(W);

    assign found_o  = |vec_i;
    // Two's-complement trick keeps only the lowest set bit.
    assign onehot_o = vec_i & (~vec_i + W'(1));

    always_comb begin
        idx_o = '0;
        for (int i = 0; i < W; i++) begin
            if (onehot_o[i]) begin
                idx_o = idx_o | IW'(i);
            end
        end
    end
endmodule

// File: rtl/slot_alloc.sv
// N-entry slot allocator: registered busy bitmap, one grant (fixed-priority or
// round-robin) and one release per cycle, plus flush and double-free detection.
module slot_alloc
    import slot_alloc_pkg::*;
#(
    parameter int N  = 32,
    parameter bit RR = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    slot_alloc_if.slave bus
);
    localparam int            IDXW  = idx_w(N);
    localparam logic [IDXW:0] N_CNT = (IDXW+1)'(N);

    logic [N-1:0]    busy_q, busy_d;
    logic [IDXW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDXW:0]   free_cnt_q, free_cnt_d;
    logic            err_q, err_d;

    logic [N-1:0]    cand;
    logic            win_found;
    logic [N-1:0]    win_oh;
    logic [IDXW-1:0] win_idx;
    logic            full, gnt, free_hit;
    logic [N-1:0]    free_oh;

    assign cand = ~busy_q;

    generate
        if (RR) begin : g_rr
            logic [N-1:0]    masked, m_oh, u_oh;
            logic            m_found, u_found;
            logic [IDXW-1:0] m_idx, u_idx;

            assign masked = cand & ({N{1'b1}} << rr_ptr_q);

            ffs_n #(.W(N)) u_ffs_masked (.vec_i(masked), .found_o(m_found), .onehot_o(m_oh), .idx_o(m_idx));
            ffs_n #(.W(N)) u_ffs_all    (.vec_i(cand),   .found_o(u_found), .onehot_o(u_oh), .idx_o(u_idx));

            // Slots at or above the pointer win; otherwise wrap to the lowest free slot.
            assign win_found = u_found;
            assign win_oh    = m_found ? m_oh  : u_oh;
            assign win_idx   = m_found ? m_idx : u_idx;
        end else begin : g_fp
            ffs_n #(.W(N)) u_ffs_all (.vec_i(cand), .found_o(win_found), .onehot_o(win_oh), .idx_o(win_idx));
        end
    endgenerate

    assign full     = (free_cnt_q == '0);
    assign gnt      = bus.alloc_req & ~full & ~bus.flush & win_found;
    assign free_oh  = {{(N-1){1'b0}}, 1'b1} << bus.free_idx;
    assign free_hit = bus.free_vld & |(busy_q & free_oh);

    always_comb begin
        busy_d     = busy_q;
        rr_ptr_d   = rr_ptr_q;
        free_cnt_d = free_cnt_q;
        err_d      = err_q;
        if (bus.flush) begin
            busy_d     = '0;
            free_cnt_d = N_CNT;
        end else begin
            // Grant targets a free slot and release a busy one, so the updates never collide.
            if (gnt) begin
                busy_d = busy_d | win_oh;
                if (RR) begin
                    rr_ptr_d = win_idx + IDXW'(1);
                end
            end
            if (free_hit) begin
                busy_d = busy_d & ~free_oh;
            end
            if (bus.free_vld && !free_hit) begin
                err_d = 1'b1;
            end
            case ({gnt, free_hit})
                2'b10:   free_cnt_d = free_cnt_q - 1'b1;
                2'b01:   free_cnt_d = free_cnt_q + 1'b1;
                default: free_cnt_d = free_cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            busy_q     <= '0;
            rr_ptr_q   <= '0;
            free_cnt_q <= N_CNT;
            err_q      <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            free_cnt_q <= free_cnt_d;
            err_q      <= err_d;
        end
    end

    assign bus.alloc_gnt    = gnt;
    assign bus.alloc_idx    = gnt ? win_idx : '0;
    assign bus.alloc_onehot = gnt ? win_oh  : '0;
    assign bus.busy_vec     = busy_q;
    assign bus.free_cnt     = free_cnt_q;
    assign bus.full         = full;
    assign bus.empty        = (free_cnt_q == N_CNT);
    assign bus.err_dbl_free = err_q;
endmodule
